// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register count of in-flight rd writes for a non-forwarding RV32I pipeline.
// Latency: id_stall_o is combinational; pending_o/busy_o/err_o are registered and update one cycle after the event.
// Backpressure: id_stall_o holds decode on a source hazard, or when rd's counter is saturated; releases always apply.
//
// Ports
//   clk_i, rst_ni                      clock (rising edge), asynchronous active-low reset
//   id_valid_i, id_rd_wren_i,
//   id_rd_addr_i                       instruction in decode and its destination
//   id_rs1_used_i/addr_i,
//   id_rs2_used_i/addr_i               source operands read by the decoded instruction
//   id_stall_o                         hold IF/ID, bubble into ID/EX
//   kill_i, kill_rd_addr_i             squashed ID/EX instruction and its rd (0 = no write)
//   wb_wren_i, wb_rd_addr_i            register file write strobe and address
//   pending_o                          bit r set while x[r] has an outstanding write (bit 0 always 0)
//   busy_o                             any register pending
//   err_o                              sticky: a release arrived for a register with nothing in flight
//   stall_cnt_o                        saturating count of stalled cycles
//                                      (present only when WB_SCOREBOARD_STATS_EN is defined)
//
// Optional build macro: WB_SCOREBOARD_STATS_EN

module wb_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                id_valid_i,
    input  logic                id_rd_wren_i,
    input  logic [ADDR_W-1:0]   id_rd_addr_i,
    input  logic                id_rs1_used_i,
    input  logic [ADDR_W-1:0]   id_rs1_addr_i,
    input  logic                id_rs2_used_i,
    input  logic [ADDR_W-1:0]   id_rs2_addr_i,
    output logic                id_stall_o,
    input  logic                kill_i,
    input  logic [ADDR_W-1:0]   kill_rd_addr_i,
    input  logic                wb_wren_i,
    input  logic [ADDR_W-1:0]   wb_rd_addr_i,
    output logic [NUM_REGS-1:0] pending_o,
    output logic                busy_o,
    output logic                err_o
`ifdef WB_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]         stall_cnt_o
`endif
);

    // One extra bit so that add/subtract of the three events can be
    // compared without wrapping.
    localparam int SUM_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    r_cnt      [NUM_REGS];
    logic [CNT_W-1:0]    w_cnt_nxt  [NUM_REGS];
    logic                r_err;

    logic [NUM_REGS-1:0] w_wbd;
    logic [NUM_REGS-1:0] w_kd;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_busy_eff;
    logic [NUM_REGS-1:0] w_uflow;

    logic                w_hz1;
    logic                w_hz2;
    logic                w_sat;
    logic                w_issue;

    // ------------------------------------------------------------------
    // Release events and effective busy.
    // A source whose remaining writes all retire (or are squashed) this
    // cycle is not busy: the register file writes through on the same
    // edge, and a squashed write will never arrive.
    // ------------------------------------------------------------------
    always_comb begin
        w_wbd      = '0;
        w_kd       = '0;
        w_busy_eff = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_wbd[r]      = wb_wren_i && (wb_rd_addr_i == ADDR_W'(r)) && (r != 0);
            w_kd[r]       = kill_i && (kill_rd_addr_i == ADDR_W'(r)) && (r != 0);
            w_busy_eff[r] = (r != 0) &&
                            ({1'b0, r_cnt[r]} > (SUM_W'(w_wbd[r]) + SUM_W'(w_kd[r])));
        end
    end

    // ------------------------------------------------------------------
    // Stall decision.
    // Saturation looks at the raw counter, not the released one: a write
    // retiring this cycle only frees the slot from the next cycle on.
    // ------------------------------------------------------------------
    always_comb begin
        w_hz1 = id_rs1_used_i && (id_rs1_addr_i != '0) && w_busy_eff[id_rs1_addr_i];
        w_hz2 = id_rs2_used_i && (id_rs2_addr_i != '0) && w_busy_eff[id_rs2_addr_i];
        w_sat = id_rd_wren_i && (id_rd_addr_i != '0) && (r_cnt[id_rd_addr_i] == CNT_MAX);
    end

    assign id_stall_o = id_valid_i && (w_hz1 || w_hz2 || w_sat);
    assign w_issue    = id_valid_i && id_rd_wren_i && !id_stall_o && (id_rd_addr_i != '0);

    // ------------------------------------------------------------------
    // Counter next state: count + inc - wbd - kd, clamped at zero.
    // Increment cannot overflow because a full counter stalls issue.
    // ------------------------------------------------------------------
    always_comb begin
        w_inc   = '0;
        w_uflow = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_inc[r]     = w_issue && (id_rd_addr_i == ADDR_W'(r)) && (r != 0);
            w_cnt_nxt[r] = '0;
            if (({1'b0, r_cnt[r]} + SUM_W'(w_inc[r])) <
                (SUM_W'(w_wbd[r]) + SUM_W'(w_kd[r]))) begin
                w_uflow[r] = 1'b1;
            end else begin
                w_cnt_nxt[r] = CNT_W'(({1'b0, r_cnt[r]} + SUM_W'(w_inc[r])) -
                                      (SUM_W'(w_wbd[r]) + SUM_W'(w_kd[r])));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
            if (|w_uflow) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status outputs, all from registered state.
    // ------------------------------------------------------------------
    always_comb begin
        pending_o = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_o[r] = (r != 0) && (r_cnt[r] != '0);
        end
    end

    assign busy_o = |pending_o;
    assign err_o  = r_err;

`ifdef WB_SCOREBOARD_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (id_stall_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_wb_scoreboard.sv
// Testbench for wb_scoreboard: directed hazard scenarios plus randomized traffic,
// checked against a counter-per-register reference model through an expectation queue.
// A monitor at the falling edge pops one expectation per driven cycle and compares.

module tb_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_wren, rs1_used, rs2_used, kill, wb_wren;
    logic [4:0]  id_rd, rs1_addr, rs2_addr, kill_rd, wb_rd;
    logic        id_stall, busy, err;
    logic [31:0] pending;
`ifdef WB_SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    wb_scoreboard dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .id_valid_i     (id_valid),
        .id_rd_wren_i   (id_wren),
        .id_rd_addr_i   (id_rd),
        .id_rs1_used_i  (rs1_used),
        .id_rs1_addr_i  (rs1_addr),
        .id_rs2_used_i  (rs2_used),
        .id_rs2_addr_i  (rs2_addr),
        .id_stall_o     (id_stall),
        .kill_i         (kill),
        .kill_rd_addr_i (kill_rd),
        .wb_wren_i      (wb_wren),
        .wb_rd_addr_i   (wb_rd),
        .pending_o      (pending),
        .busy_o         (busy),
        .err_o          (err)
`ifdef WB_SCOREBOARD_STATS_EN
        ,
        .stall_cnt_o    (stall_cnt)
`endif
    );

    typedef struct {
        bit          stall;
        bit [31:0]   pend;
        bit          busy;
        bit          err;
        int unsigned scnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          m_cnt[32];
    bit          m_err;
    int unsigned m_scnt;
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    // Number of in-flight writes to r that retire or are squashed this cycle.
    function automatic int released(input int r, input bit k, input int krd,
                                    input bit w, input int wrd);
        int n;
        n = 0;
        if (r != 0 && w && wrd == r) n++;
        if (r != 0 && k && krd == r) n++;
        return n;
    endfunction

    function automatic bit src_busy(input int r, input bit k, input int krd,
                                    input bit w, input int wrd);
        return (r != 0) && (m_cnt[r] - released(r, k, krd, w, wrd) > 0);
    endfunction

    task automatic model_reset();
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_err  = 0;
        m_scnt = 0;
    endtask

    // Drive one cycle of inputs, push the expected outputs for that cycle,
    // then advance the model to the state the DUT holds after the next edge.
    task automatic drive(input bit v, input bit wr, input int rd,
                         input bit u1, input int a1, input bit u2, input int a2,
                         input bit k, input int krd, input bit w, input int wrd);
        exp_t e;
        bit   hz1, hz2, sat;
        int   n;
        @(posedge clk);
        #1;
        id_valid = v;  id_wren  = wr; id_rd    = 5'(rd);
        rs1_used = u1; rs1_addr = 5'(a1);
        rs2_used = u2; rs2_addr = 5'(a2);
        kill     = k;  kill_rd  = 5'(krd);
        wb_wren  = w;  wb_rd    = 5'(wrd);

        hz1 = u1 && src_busy(a1, k, krd, w, wrd);
        hz2 = u2 && src_busy(a2, k, krd, w, wrd);
        sat = wr && rd != 0 && m_cnt[rd] == 3;
        e.stall = v && (hz1 || hz2 || sat);
        e.pend  = '0;
        for (int r = 1; r < 32; r++) e.pend[r] = (m_cnt[r] > 0);
        e.busy  = (e.pend != 0);
        e.err   = m_err;
        e.scnt  = m_scnt;
        exp_q.push_back(e);

        if (e.stall) m_scnt++;
        for (int r = 1; r < 32; r++) begin
            n = m_cnt[r] - released(r, k, krd, w, wrd);
            if (v && wr && !e.stall && rd == r) n++;
            if (n < 0) begin
                n     = 0;
                m_err = 1;
            end
            m_cnt[r] = n;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("id_stall", id_stall, mon_e.stall);
            check("pending",  pending,  mon_e.pend);
            check("busy",     busy,     mon_e.busy);
            check("err",      err,      mon_e.err);
`ifdef WB_SCOREBOARD_STATS_EN
            check("stall_cnt", stall_cnt, mon_e.scnt);
`endif
        end
    end

    initial begin
        bit v, wr, u1, u2, k, w;
        int rd, a1, a2, krd, wrd;

        rst_n = 0;
        id_valid = 0; id_wren = 0; id_rd = 0;
        rs1_used = 0; rs1_addr = 0; rs2_used = 0; rs2_addr = 0;
        kill = 0; kill_rd = 0; wb_wren = 0; wb_rd = 0;
        model_reset();
        #12;
        check("reset_pending", pending, 0);
        check("reset_busy",    busy,    0);
        check("reset_err",     err,     0);
        check("reset_stall",   id_stall, 0);
`ifdef WB_SCOREBOARD_STATS_EN
        check("reset_stall_cnt", stall_cnt, 0);
`endif
        rst_n = 1;

        // RAW on x5: issue, reader stalls while pending, wb cycle credits bypass.
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 5, 0, 0, 0, 0, 1, 5);
        idle();

        // x0 destination never counts; unused rs2 never stalls.
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);

        // Kill of x3: a reader in the kill cycle is not stalled.
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 3, 0, 0, 1, 3, 0, 0);
        idle();

        // Saturation on x9 with 2-bit counters.
        for (int i = 0; i < 4; i++) drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 1, 9);
        drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        drive(1, 0, 0, 1, 9, 0, 0, 0, 0, 1, 9);
        idle();

        // Same-cycle issue and writeback on x4 nets to no change.
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 1, 4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        idle();

        // Randomized traffic on x0..x7; releases mostly target pending registers.
        for (int i = 0; i < 1500; i++) begin
            v   = ($urandom_range(0, 9) != 0);
            wr  = ($urandom_range(0, 3) != 0);
            rd  = $urandom_range(0, 7);
            u1  = $urandom_range(0, 1);
            a1  = $urandom_range(0, 7);
            u2  = $urandom_range(0, 1);
            a2  = $urandom_range(0, 7);
            wrd = $urandom_range(0, 7);
            w   = ($urandom_range(0, 2) != 0);
            if (w && m_cnt[wrd] == 0 && $urandom_range(0, 49) != 0) w = 0;
            krd = $urandom_range(0, 7);
            k   = ($urandom_range(0, 7) == 0);
            if (k && m_cnt[krd] == 0 && $urandom_range(0, 49) != 0) k = 0;
            drive(v, wr, rd, u1, a1, u2, a2, k, krd, w, wrd);
        end
        for (int i = 0; i < 8; i++)
            for (int r = 1; r < 8; r++)
                if (m_cnt[r] > 0) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, r);
        idle();

        // Underflow on x6 after a clean reset: err sets and stays set.
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        for (int i = 0; i < 3; i++) idle();

        // Build up state, then reset asynchronously between edges.
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 2, 1, 8, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check("async_rst_pending", pending, 0);
        check("async_rst_busy",    busy,    0);
        check("async_rst_err",     err,     0);
        check("async_rst_stall",   id_stall, 0);
`ifdef WB_SCOREBOARD_STATS_EN
        check("async_rst_stall_cnt", stall_cnt, 0);
`endif
        model_reset();
        #1;
        rst_n = 1;
        drive(1, 0, 0, 1, 2, 1, 8, 0, 0, 0, 0);
        idle();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
